fft_bitrev_reorder: RTL

- Output reorder buffer for the R22SDF FFT pipeline.
- Accepts the bit-reversed complex sample stream leaving the last butterfly stage and emits the same frame in natural bin order (bin 0 first).
- Uses a ping-pong pair of frame banks, so one frame is written while the previous one is read.
- Sits between the FFT core output and the downstream consumer; it supports input stall and output backpressure.

---
 rtl/fft_bitrev_reorder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural bin order out.
// Define FFT_REORDER_ERR_EN to add the sticky overflow flag err_o.
module fft_bitrev_reorder #(
    parameter int DW    = 25,
    parameter int N     = 1024,
    parameter int LOG2N = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DW-1:0]    x_re_i,
    input  logic [DW-1:0]    x_im_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DW-1:0]    z_re_o,
    output logic [DW-1:0]    z_im_o,
    output logic [LOG2N-1:0] idx_o,
`ifdef FFT_REORDER_ERR_EN
    output logic             err_o,
`endif
    output logic             last_o
);

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

    logic [2*DW-1:0]  bank0 [N];
    logic [2*DW-1:0]  bank1 [N];

    logic [1:0]       full_q;
    logic [1:0]       full_d;
    logic             wb_q;
    logic             wb_d;
    logic             rb_q;
    logic             rb_d;
    logic [LOG2N-1:0] wcnt_q;
    logic [LOG2N-1:0] wcnt_d;
    logic [LOG2N-1:0] rcnt_q;
    logic [LOG2N-1:0] rcnt_d;
    logic [LOG2N-1:0] waddr;

    logic             ready_q;
    logic             valid_q;
    logic             last_q;
    logic [LOG2N-1:0] idx_q;
    logic [2*DW-1:0]  rd_q;
    logic             loaded_q;

    logic             wr_en;
    logic             wr_last;
    logic             rd_en;
    logic             rd_last;
    logic             hs_out;

    assign wr_en   = valid_i && ready_q;
    assign wr_last = (wcnt_q == CNT_LAST);
    assign rd_en   = full_q[rb_q] && (!valid_q || ready_i);
    assign rd_last = (rcnt_q == CNT_LAST);
    assign hs_out  = valid_q && ready_i;

    always_comb begin
        waddr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            waddr[i] = wcnt_q[LOG2N-1-i];
        end
    end

    // Read side frees a bank at issue time; the write side fills the other one.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wr_en) begin
            if (wr_last) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
                wcnt_d       = '0;
            end else begin
                wcnt_d = wcnt_q + CNT_ONE;
            end
        end
        if (rd_en) begin
            if (rd_last) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
                rcnt_d       = '0;
            end else begin
                rcnt_d = rcnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q  <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            ready_q <= !full_d[wb_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !wb_q) begin
            bank0[waddr] <= {x_re_i, x_im_i};
        end
        if (wr_en && wb_q) begin
            bank1[waddr] <= {x_re_i, x_im_i};
        end
    end

    // Read register kept reset-free so the banks map onto synchronous RAM.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_q <= rb_q ? bank1[rcnt_q] : bank0[rcnt_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else if (rd_en) begin
            valid_q  <= 1'b1;
            idx_q    <= rcnt_q;
            last_q   <= rd_last;
            loaded_q <= 1'b1;
        end else if (hs_out) begin
            valid_q <= 1'b0;
        end
    end

`ifdef FFT_REORDER_ERR_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_o <= 1'b0;
        end else if (valid_i && !ready_q) begin
            err_o <= 1'b1;
        end
    end
`endif

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
    assign z_re_o  = rd_q[2*DW-1:DW] & {DW{loaded_q}};
    assign z_im_o  = rd_q[DW-1:0] & {DW{loaded_q}};

endmodule
